// File: rtl/ahb_lite_pkg.sv
// -----------------------------------------------------------------------------
// ahb_lite_pkg
// Shared AHB-Lite definitions for the master's command path.
//   BUS_WIDTH              : default address/data width.
//   HSIZE_BYTE/HALF/WORD   : HSIZE transfer-size encodings.
//   cmd_t                  : one queued bus command {write, addr, data, size}.
// -----------------------------------------------------------------------------
package ahb_lite_pkg;

   localparam int BUS_WIDTH = 32;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef struct packed {
      logic                 write;
      logic [BUS_WIDTH-1:0] addr;
      logic [BUS_WIDTH-1:0] data;
      logic [2:0]           size;
   } cmd_t;

endpackage

// File: rtl/cmd_fifo_mem.sv
// -----------------------------------------------------------------------------
// cmd_fifo_mem
// DEPTH x cmd_t register array used as storage for cmd_fifo.
// Contents are intentionally not reset; validity is tracked by the pointers.
//   HCLK     : clock, write occurs on rising edge
//   wr_en    : write strobe
//   wr_addr  : write slot index
//   wr_cmd   : command to store
//   rd_addr  : read slot index (asynchronous read)
//   rd_cmd   : command currently stored at rd_addr
// -----------------------------------------------------------------------------
module cmd_fifo_mem
   import ahb_lite_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          HCLK,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  cmd_t          wr_cmd,
   input  logic [AW-1:0] rd_addr,
   output cmd_t          rd_cmd
);

   cmd_t mem_r [DEPTH];

   // Synchronous write port.
   always_ff @(posedge HCLK) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_cmd;
      end
   end

   // Asynchronous read port feeds the first-word-fall-through head.
   assign rd_cmd = mem_r[rd_addr];

endmodule

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// First-word-fall-through command queue between the AHB-Lite scheduler and
// the transfer engine. Circular buffer with wrap-bit pointers.
// Optional feature: define CMD_FIFO_COUNT_EN to add the registered count_o.
//   HCLK, HRESETn        : clock / asynchronous active-low reset
//   push_i, push_*_i     : enqueue request and command fields
//   pop_i                : dequeue request (acts on the visible head)
//   head_*_o             : command at the head, all zero while empty
//   empty_o, full_o      : occupancy flags (derived from pointer registers)
//   count_o              : occupancy 0..DEPTH (CMD_FIFO_COUNT_EN only)
// BUS_WIDTH must match ahb_lite_pkg::BUS_WIDTH since cmd_t is sized by it.
// -----------------------------------------------------------------------------
module cmd_fifo
   import ahb_lite_pkg::*;
#(
   parameter int BUS_WIDTH = ahb_lite_pkg::BUS_WIDTH,
   parameter int DEPTH     = 8
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 push_i,
   input  logic                 push_write_i,
   input  logic [BUS_WIDTH-1:0] push_addr_i,
   input  logic [BUS_WIDTH-1:0] push_data_i,
   input  logic [2:0]           push_size_i,
   input  logic                 pop_i,
   output logic                 head_write_o,
   output logic [BUS_WIDTH-1:0] head_addr_o,
   output logic [BUS_WIDTH-1:0] head_data_o,
   output logic [2:0]           head_size_o,
   output logic                 empty_o,
   output logic                 full_o
`ifdef CMD_FIFO_COUNT_EN
   ,
   output logic [$clog2(DEPTH):0] count_o
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic          empty_s;
   logic          full_s;
   logic          pop_ok_s;
   logic          push_ok_s;
   cmd_t          push_cmd_s;
   cmd_t          rd_cmd_s;
   cmd_t          head_s;

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                    (wr_ptr_r[AW] != rd_ptr_r[AW]);

   // A full FIFO still takes a push when the head leaves on the same edge.
   assign pop_ok_s  = pop_i & ~empty_s;
   assign push_ok_s = push_i & (~full_s | pop_ok_s);

   assign push_cmd_s = '{write: push_write_i, addr: push_addr_i,
                         data: push_data_i, size: push_size_i};

   cmd_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .HCLK    (HCLK),
      .wr_en   (push_ok_s),
      .wr_addr (wr_ptr_r[AW-1:0]),
      .wr_cmd  (push_cmd_s),
      .rd_addr (rd_ptr_r[AW-1:0]),
      .rd_cmd  (rd_cmd_s)
   );

   // Pointer update; the wrap bit rolls over naturally modulo 2*DEPTH.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
      end
   end

`ifdef CMD_FIFO_COUNT_EN
   logic [PW-1:0] count_r;

   // Occupancy register tracks wr_ptr - rd_ptr on the same edge as the pointers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         count_r <= '0;
      end else begin
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + PW'(1);
            2'b01:   count_r <= count_r - PW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign count_o = count_r;
`endif

   // Head is blanked while empty so stale storage never leaks out.
   always_comb begin
      head_s = '0;
      if (empty_s) begin
         head_s = '0;
      end else begin
         head_s = rd_cmd_s;
      end
   end

   assign head_write_o = head_s.write;
   assign head_addr_o  = head_s.addr;
   assign head_data_o  = head_s.data;
   assign head_size_o  = head_s.size;
   assign empty_o      = empty_s;
   assign full_o       = full_s;

endmodule

// File: tb/tb_cmd_fifo.sv
module tb_cmd_fifo;
   import ahb_lite_pkg::*;

   localparam int DEPTH = 8;
   localparam int BW    = ahb_lite_pkg::BUS_WIDTH;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          push_i = 1'b0;
   logic          push_write_i = 1'b0;
   logic [BW-1:0] push_addr_i = '0;
   logic [BW-1:0] push_data_i = '0;
   logic [2:0]    push_size_i = 3'b000;
   logic          pop_i = 1'b0;
   logic          head_write_o;
   logic [BW-1:0] head_addr_o;
   logic [BW-1:0] head_data_o;
   logic [2:0]    head_size_o;
   logic          empty_o;
   logic          full_o;
`ifdef CMD_FIFO_COUNT_EN
   logic [$clog2(DEPTH):0] count_o;
`endif

   int checks = 0;
   int failures = 0;

   cmd_fifo #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .push_i       (push_i),
      .push_write_i (push_write_i),
      .push_addr_i  (push_addr_i),
      .push_data_i  (push_data_i),
      .push_size_i  (push_size_i),
      .pop_i        (pop_i),
      .head_write_o (head_write_o),
      .head_addr_o  (head_addr_o),
      .head_data_o  (head_data_o),
      .head_size_o  (head_size_o),
      .empty_o      (empty_o),
      .full_o       (full_o)
`ifdef CMD_FIFO_COUNT_EN
      ,
      .count_o      (count_o)
`endif
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a plain queue of commands.
   cmd_t model_q[$];
   bit   m_pop_ok;
   bit   m_push_ok;
   cmd_t m_in;

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         model_q.delete();
      end else begin
         m_in = '{write: push_write_i, addr: push_addr_i, data: push_data_i, size: push_size_i};
         m_pop_ok  = pop_i && (model_q.size() != 0);
         m_push_ok = push_i && ((model_q.size() < DEPTH) || m_pop_ok);
         if (m_pop_ok) void'(model_q.pop_front());
         if (m_push_ok) model_q.push_back(m_in);
      end
   end

   // Compare DUT against the model once per cycle, away from the active edge.
   cmd_t exp_head;
   always @(negedge HCLK) begin
      exp_head = (model_q.size() != 0) ? model_q[0] : '0;
      check("empty", 64'(empty_o), 64'(model_q.size() == 0));
      check("full",  64'(full_o),  64'(model_q.size() == DEPTH));
      check("head_write", 64'(head_write_o), 64'(exp_head.write));
      check("head_addr",  64'(head_addr_o),  64'(exp_head.addr));
      check("head_data",  64'(head_data_o),  64'(exp_head.data));
      check("head_size",  64'(head_size_o),  64'(exp_head.size));
`ifdef CMD_FIFO_COUNT_EN
      check("count", 64'(count_o), 64'(model_q.size()));
`endif
   end

   // One clock cycle of stimulus; called and returns at a falling edge.
   task automatic step(input bit push, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] size, input bit pop);
      push_i = push; push_write_i = wr; push_addr_i = addr;
      push_data_i = data; push_size_i = size; pop_i = pop;
      @(negedge HCLK);
      push_i = 1'b0; pop_i = 1'b0;
   endtask

   task automatic check_count(input string name, input int exp);
`ifdef CMD_FIFO_COUNT_EN
      check(name, 64'(count_o), 64'(exp));
`else
      check(name, 64'(model_q.size()), 64'(exp));
`endif
   endtask

   initial begin
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);

      // Reset / idle
      check("rst_empty", 64'(empty_o), 64'd1);
      check("rst_full",  64'(full_o),  64'd0);
      check("rst_head",  64'(head_addr_o), 64'd0);
      check_count("rst_count", 0);
      repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
      check("idle_pop_empty", 64'(empty_o), 64'd1);
      check("idle_pop_head",  64'(head_data_o), 64'd0);

      // Single push then pop
      step(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, HSIZE_WORD, 1'b0);
      check("one_empty", 64'(empty_o), 64'd0);
      check("one_write", 64'(head_write_o), 64'd1);
      check("one_addr",  64'(head_addr_o), 64'h10);
      check("one_data",  64'(head_data_o), 64'hDEAD_BEEF);
      check("one_size",  64'(head_size_o), 64'd2);
      step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
      check("one_pop_empty", 64'(empty_o), 64'd1);

      // Fill, overflow drop, drain in order
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'(i * 4), 32'(i), HSIZE_WORD, 1'b0);
      check("fill_full", 64'(full_o), 64'd1);
      check_count("fill_count", 8);
      step(1'b1, 1'b0, 32'h20, 32'h0, HSIZE_WORD, 1'b0);
      check("drop_full", 64'(full_o), 64'd1);
      check("drop_head", 64'(head_addr_o), 64'h0);
      for (int i = 0; i < 8; i++) begin
         check("drain_order", 64'(head_addr_o), 64'(i * 4));
         step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
      end
      check("drain_empty", 64'(empty_o), 64'd1);

      // Push + pop while full
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'(i * 4), 32'(i), HSIZE_WORD, 1'b0);
      check("pp_head0", 64'(head_addr_o), 64'h0);
      step(1'b1, 1'b1, 32'h40, 32'h4040, HSIZE_WORD, 1'b1);
      check("pp_full", 64'(full_o), 64'd1);
      check_count("pp_count", 8);
      check("pp_head1", 64'(head_addr_o), 64'h4);
      repeat (7) step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
      check("pp_last", 64'(head_addr_o), 64'h40);
      step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
      check("pp_empty", 64'(empty_o), 64'd1);

      // Wrap-around with steady occupancy of 1
      step(1'b1, 1'b0, 32'h100, 32'hA000_0000, HSIZE_BYTE, 1'b0);
      for (int i = 0; i < 20; i++) begin
         check("wrap_head", 64'(head_addr_o), 64'(32'h100 + i * 4));
         check("wrap_dir",  64'(head_write_o), 64'((i % 2) == 1));
         step(1'b1, ((i % 2) == 0), 32'(32'h104 + i * 4), 32'(32'hA000_0001 + i),
              ((i % 2) == 0) ? HSIZE_HALF : HSIZE_BYTE, 1'b1);
         check_count("wrap_count", 1);
      end
      step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
      check("wrap_empty", 64'(empty_o), 64'd1);

      // Asynchronous reset mid-operation
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'(32'h300 + i), 32'(i), HSIZE_WORD, 1'b0);
      check("pre_rst_empty", 64'(empty_o), 64'd0);
      @(posedge HCLK);
      #2 HRESETn = 1'b0;
      #1 check("async_rst_empty", 64'(empty_o), 64'd1);
      check("async_rst_head", 64'(head_addr_o), 64'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      step(1'b1, 1'b0, 32'h200, 32'h55, HSIZE_WORD, 1'b0);
      check("post_rst_head", 64'(head_addr_o), 64'h200);
      step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
      check("post_rst_empty", 64'(empty_o), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmd_fifo.md
# cmd_fifo

Synchronous command queue between the AHB-Lite master's scheduling logic and its transfer engine. Each entry holds one bus command: direction, address, write data, transfer size. The master pushes commands at any time and pops one per cycle while HREADY is high. Head is first-word-fall-through, so the popped command is valid combinationally in the same cycle.

## Interface
Parameters:
- BUS_WIDTH, 32: address and data width.
- DEPTH, 8: number of entries; power of two, at least 2.

Ports (reset HRESETn, asynchronous, active-low; clock HCLK):
- HCLK  in  1  clock, all state updates on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- push_i  in  1  enqueue request.
- push_write_i  in  1  command direction, 1 = write, 0 = read.
- push_addr_i  in  BUS_WIDTH  command address.
- push_data_i  in  BUS_WIDTH  write data; stored but meaningless for reads.
- push_size_i  in  3  HSIZE encoding.
- pop_i  in  1  dequeue request.
- head_write_o  out  1  head direction.
- head_addr_o  out  BUS_WIDTH  head address.
- head_data_o  out  BUS_WIDTH  head data.
- head_size_o  out  3  head size.
- empty_o  out  1  no valid entries.
- full_o  out  1  DEPTH valid entries.
- count_o  out  $clog2(DEPTH)+1  occupancy; present only with CMD_FIFO_COUNT_EN.

## Operation
- Storage is a circular buffer with write pointer wr_ptr and read pointer rd_ptr.
  - Each pointer is $clog2(DEPTH)+1 bits; the extra MSB is a wrap bit.
  - empty_o = (wr_ptr == rd_ptr).
  - full_o = LSBs equal and MSBs differ.
- Push is accepted when push_i is high and the FIFO is not full, or when it is full and a pop is accepted in the same cycle. An accepted push writes {write, addr, data, size} at wr_ptr and increments wr_ptr.
- A push while full with no pop is dropped silently; no state changes.
- Pop is accepted when pop_i is high and empty_o is low. An accepted pop increments rd_ptr.
- A pop while empty is ignored; pointers do not change.
- Head outputs show the entry at rd_ptr. All head outputs are forced to 0 while empty_o = 1.
- Simultaneous accepted push and pop:
  - occupancy is unchanged;
  - when the FIFO is empty, no pop is accepted, so only the push takes effect.
- Pointers wrap modulo 2·DEPTH. Ordering is strict FIFO.

## Timing
- Reset values: wr_ptr = rd_ptr = 0, empty_o = 1, full_o = 0, head outputs 0, count_o = 0. Storage contents are not reset.
- Reset asserted mid-operation discards all entries immediately and asynchronously.
- Push-to-head latency is 1 cycle. After a push into an empty FIFO at edge N, empty_o falls and the head outputs are valid after edge N.
- Pop consumes the head at the edge; the next entry appears after that edge.
- Flags and head outputs depend only on registers, with no combinational path from push_i or pop_i.
- Throughput is one push and one pop per cycle.

## Configuration
- CMD_FIFO_COUNT_EN defined:
  - count_o port exists, registered;
  - count_o = wr_ptr − rd_ptr (modulo the pointer width), range 0..DEPTH;
  - count_o updates on the same edge as the pointers.
- CMD_FIFO_COUNT_EN undefined: count_o and its logic are absent. All other behaviour is identical.

## Structure
- Shared package ahb_lite_pkg holds:
  - BUS_WIDTH default constant;
  - HSIZE encodings (BYTE = 3'b000, HALF = 3'b001, WORD = 3'b010);
  - typedef struct cmd_t {logic write; logic [BUS_WIDTH-1:0] addr; logic [BUS_WIDTH-1:0] data; logic [2:0] size;}.
- One sub-module, cmd_fifo_mem:
  - DEPTH × cmd_t register array;
  - one synchronous write port and one asynchronous read port.
- Pointer and flag logic stays in cmd_fifo.

## Test plan
- Reset then idle: expect empty_o = 1, full_o = 0, head outputs 0, count_o = 0; pop_i = 1 for 3 cycles leaves all of them unchanged.
- Push {1, 0x0000_0010, 0xDEAD_BEEF, 3'b010} once: one cycle later empty_o = 0 and the head equals the pushed command. Pop once: empty_o = 1 the next cycle.
- Push 8 commands with addr 0x00..0x1C, step 4: full_o = 1 and count_o = 8. A 9th push with addr 0x20 is dropped. 8 pops return 0x00..0x1C in order, then empty_o = 1.
- While full, push addr 0x40 and pop in the same cycle: the pop returns 0x00, count stays 8, and 0x40 is returned last.
- Wrap-around: 20 cycles of push plus pop with alternating write/read commands. The sequence comes out intact and count_o stays 1 after the first push.
- Push 3 entries, assert HRESETn low mid-cycle: empty_o = 1 immediately. After release, one push then one pop returns only the new entry.
